// File: rtl/cpu_pkg.sv
// Shared CPU types: datapath widths, ALU opcodes and the ID/EX stored-entry record.
// Used by id_ex_stage (optional forwarding controlled by ID_EX_FORWARD_EN).
package cpu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RA_W  = 5;
  localparam int unsigned ALU_W = 4;

  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_SRA  = 4'b1101;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'b0111;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [RA_W-1:0]  rs1_addr;
    logic [RA_W-1:0]  rs2_addr;
    logic [RA_W-1:0]  rd_addr;
    logic [ALU_W-1:0] alu_sel;
    logic             a_sel;
    logic             b_sel;
    logic             reg_wen;
  } id_ex_t;

  // True when the opcode is one the ALU implements.
  function automatic logic is_alu_op(input logic [ALU_W-1:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SLL) || (op == ALU_SRL) ||
           (op == ALU_SRA) || (op == ALU_SLT) || (op == ALU_SLTU) || (op == ALU_XOR) ||
           (op == ALU_OR)  || (op == ALU_AND);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of the ID/EX stage handshakes, decoded fields, forwarding sources and ALU operands.
// Forwarding inputs are only honoured when ID_EX_FORWARD_EN is defined.
interface id_ex_stage_if;
  import cpu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_rs1_data;
  logic [XLEN-1:0]  in_rs2_data;
  logic [XLEN-1:0]  in_imm;
  logic [RA_W-1:0]  in_rs1_addr;
  logic [RA_W-1:0]  in_rs2_addr;
  logic [RA_W-1:0]  in_rd_addr;
  logic [ALU_W-1:0] in_alu_sel;
  logic             in_a_sel;
  logic             in_b_sel;
  logic             in_reg_wen;
  logic             flush;

  logic             fwd_mem_wen;
  logic [RA_W-1:0]  fwd_mem_rd;
  logic [XLEN-1:0]  fwd_mem_data;
  logic             fwd_wb_wen;
  logic [RA_W-1:0]  fwd_wb_rd;
  logic [XLEN-1:0]  fwd_wb_data;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  alu_a;
  logic [XLEN-1:0]  alu_b;
  logic [ALU_W-1:0] alu_sel;
  logic [XLEN-1:0]  out_rs2_data;
  logic [XLEN-1:0]  out_pc;
  logic [RA_W-1:0]  out_rd_addr;
  logic             out_reg_wen;

  modport master (
    output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
           in_rs1_addr, in_rs2_addr, in_rd_addr, in_alu_sel,
           in_a_sel, in_b_sel, in_reg_wen, flush,
           fwd_mem_wen, fwd_mem_rd, fwd_mem_data,
           fwd_wb_wen, fwd_wb_rd, fwd_wb_data, out_ready,
    input  in_ready, out_valid, alu_a, alu_b, alu_sel,
           out_rs2_data, out_pc, out_rd_addr, out_reg_wen
  );

  modport slave (
    input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
           in_rs1_addr, in_rs2_addr, in_rd_addr, in_alu_sel,
           in_a_sel, in_b_sel, in_reg_wen, flush,
           fwd_mem_wen, fwd_mem_rd, fwd_mem_data,
           fwd_wb_wen, fwd_wb_rd, fwd_wb_data, out_ready,
    output in_ready, out_valid, alu_a, alu_b, alu_sel,
           out_rs2_data, out_pc, out_rd_addr, out_reg_wen
  );

endinterface

// File: rtl/fwd_mux.sv
// Operand forwarding select: MEM result over WB result over register-file value, x0 never forwarded.
// Without ID_EX_FORWARD_EN the raw value passes straight through.
module fwd_mux
  import cpu_pkg::*;
(
  input  logic [RA_W-1:0] addr,
  input  logic [XLEN-1:0] raw,
  input  logic            mem_wen,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_wen,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] result
);

`ifdef ID_EX_FORWARD_EN
  always_comb begin
    result = raw;
    if (addr != RA_W'(0)) begin
      if (mem_wen && (mem_rd == addr)) begin
        result = mem_data;
      end else if (wb_wen && (wb_rd == addr)) begin
        result = wb_data;
      end
    end
  end
`else
  // Producer ports are tied off; the hazard unit stalls instead.
  logic unused_fwd;
  assign unused_fwd = ^{addr, mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data};
  assign result     = raw;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register presenting forwarded, muxed ALU operands.
// ID_EX_FORWARD_EN enables result forwarding and stall-time operand refresh.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  id_ex_stage_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state_q, state_d;
  id_ex_t          entry_q, entry_d;
  logic            full;
  logic            accept;
  logic            drain;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  assign full         = (state_q == FULL);
  assign bus.in_ready = !full || bus.out_ready || bus.flush;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  assign drain        = full && bus.out_ready;

  fwd_mux u_fwd_rs1 (
    .addr     (entry_q.rs1_addr),
    .raw      (entry_q.rs1_data),
    .mem_wen  (bus.fwd_mem_wen),
    .mem_rd   (bus.fwd_mem_rd),
    .mem_data (bus.fwd_mem_data),
    .wb_wen   (bus.fwd_wb_wen),
    .wb_rd    (bus.fwd_wb_rd),
    .wb_data  (bus.fwd_wb_data),
    .result   (rs1_fwd)
  );

  fwd_mux u_fwd_rs2 (
    .addr     (entry_q.rs2_addr),
    .raw      (entry_q.rs2_data),
    .mem_wen  (bus.fwd_mem_wen),
    .mem_rd   (bus.fwd_mem_rd),
    .mem_data (bus.fwd_mem_data),
    .wb_wen   (bus.fwd_wb_wen),
    .wb_rd    (bus.fwd_wb_rd),
    .wb_data  (bus.fwd_wb_data),
    .result   (rs2_fwd)
  );

  // Flush wins over everything; a stalled entry captures forwarded operands so they outlive the producer.
  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d = FULL;
      entry_d = '{pc:       bus.in_pc,
                  rs1_data: bus.in_rs1_data,
                  rs2_data: bus.in_rs2_data,
                  imm:      bus.in_imm,
                  rs1_addr: bus.in_rs1_addr,
                  rs2_addr: bus.in_rs2_addr,
                  rd_addr:  bus.in_rd_addr,
                  alu_sel:  bus.in_alu_sel,
                  a_sel:    bus.in_a_sel,
                  b_sel:    bus.in_b_sel,
                  reg_wen:  bus.in_reg_wen};
    end else if (drain) begin
      state_d = EMPTY;
`ifdef ID_EX_FORWARD_EN
    end else if (full) begin
      entry_d.rs1_data = rs1_fwd;
      entry_d.rs2_data = rs2_fwd;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      entry_q <= '0;
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
    end
  end

  assign bus.out_valid    = full;
  assign bus.alu_a        = entry_q.a_sel ? entry_q.pc  : rs1_fwd;
  assign bus.alu_b        = entry_q.b_sel ? entry_q.imm : rs2_fwd;
  assign bus.out_rs2_data = rs2_fwd;
  assign bus.alu_sel      = entry_q.alu_sel;
  assign bus.out_pc       = entry_q.pc;
  assign bus.out_rd_addr  = entry_q.rd_addr;
  assign bus.out_reg_wen  = entry_q.reg_wen;

endmodule
